// File: rtl/alarm_annunciator_pkg.sv
// Shared alarm-system definitions: annunciator state encoding, tone select and
// default timing constants for the output stage.
package alarm_annunciator_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StChirpOn,
    StChirpOff,
    StSound,
    StHoldoff
  } ann_state_e;

  typedef enum logic {
    ToneHi,
    ToneLo
  } tone_e;

  localparam int unsigned DefHiHalf    = 2;
  localparam int unsigned DefLoHalf    = 3;
  localparam int unsigned DefWarbleLen = 12;
  localparam int unsigned DefFlashHalf = 4;
  localparam int unsigned DefChirpLen  = 3;
  localparam int unsigned DefChirpGap  = 2;
  localparam int unsigned DefSirenMax  = 40;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_annunciator_if.sv
// Controller-to-annunciator signal bundle; master is the alarm controller side,
// slave is the annunciator output stage.
interface alarm_annunciator_if;

  logic system_arm;
  logic siren_req;
  logic spk;
  logic horn;
  logic lamp;
  logic timed_out;

  modport master (
    output system_arm,
    output siren_req,
    input  spk,
    input  horn,
    input  lamp,
    input  timed_out
  );

  modport slave (
    input  system_arm,
    input  siren_req,
    output spk,
    output horn,
    output lamp,
    output timed_out
  );

endinterface

// File: rtl/annunciator_tone_gen.sv
// Two-tone warbling speaker square wave; restarts from high tone with spk low
// whenever start is pulsed, and idles low while run is low.
module annunciator_tone_gen
  import alarm_annunciator_pkg::*;
#(
  parameter int unsigned HI_HALF    = DefHiHalf,
  parameter int unsigned LO_HALF    = DefLoHalf,
  parameter int unsigned WARBLE_LEN = DefWarbleLen,
  parameter int unsigned CW         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic start,
  output logic spk
);

  logic [CW-1:0] half_q, half_d;
  logic [CW-1:0] warble_q, warble_d;
  logic [CW-1:0] half_max;
  tone_e         tone_q, tone_d;
  logic          spk_q, spk_d;

  assign half_max = (tone_q == ToneHi) ? CW'(HI_HALF - 1) : CW'(LO_HALF - 1);

  always_comb begin
    half_d   = half_q;
    warble_d = warble_q;
    tone_d   = tone_q;
    spk_d    = spk_q;
    if (!run || start) begin
      half_d   = '0;
      warble_d = '0;
      tone_d   = ToneHi;
      spk_d    = 1'b0;
    end else if (warble_q == CW'(WARBLE_LEN - 1)) begin
      // Tone change wins over a coincident half-period toggle; spk holds its level.
      warble_d = '0;
      half_d   = '0;
      tone_d   = (tone_q == ToneHi) ? ToneLo : ToneHi;
    end else begin
      warble_d = warble_q + 1'b1;
      if (half_q == half_max) begin
        half_d = '0;
        spk_d  = ~spk_q;
      end else begin
        half_d = half_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q   <= '0;
      warble_q <= '0;
      tone_q   <= ToneHi;
      spk_q    <= 1'b0;
    end else begin
      half_q   <= half_d;
      warble_q <= warble_d;
      tone_q   <= tone_d;
      spk_q    <= spk_d;
    end
  end

  assign spk = spk_q;

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm output stage: warbling siren, horn relay, hazard flash and arm/disarm chirps.
// Optional siren timeout into HOLDOFF is built when ANNUNCIATOR_SIREN_TIMEOUT_EN is defined.
module alarm_annunciator
  import alarm_annunciator_pkg::*;
#(
  parameter int unsigned HI_HALF    = DefHiHalf,
  parameter int unsigned LO_HALF    = DefLoHalf,
  parameter int unsigned WARBLE_LEN = DefWarbleLen,
  parameter int unsigned FLASH_HALF = DefFlashHalf,
  parameter int unsigned CHIRP_LEN  = DefChirpLen,
  parameter int unsigned CHIRP_GAP  = DefChirpGap,
  parameter int unsigned SIREN_MAX  = DefSirenMax
) (
  input logic               clk,
  input logic               rst,
  alarm_annunciator_if.slave bus
);

  localparam int unsigned MaxParam = max_u(max_u(max_u(HI_HALF, LO_HALF),
                                                 max_u(WARBLE_LEN, FLASH_HALF)),
                                           max_u(max_u(CHIRP_LEN, CHIRP_GAP), SIREN_MAX));
  localparam int unsigned CW = $clog2(MaxParam) + 1;

  ann_state_e    state_q, state_d;
  logic [1:0]    chirps_q, chirps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] flash_q, flash_d;
  logic          arm_q;
  logic          edge_ok_q;
  logic          horn_q, horn_d;
  logic          lamp_q, lamp_d;
  logic          arm_rise, arm_fall;
  logic          tone_run, tone_start;
  logic          spk;
`ifdef ANNUNCIATOR_SIREN_TIMEOUT_EN
  logic [CW-1:0] snd_q, snd_d;
  logic          timed_out_q;
`endif

  // Edges are masked on the first cycle after reset so a held arm level never chirps.
  assign arm_rise = edge_ok_q & bus.system_arm & ~arm_q;
  assign arm_fall = edge_ok_q & ~bus.system_arm & arm_q;

  always_comb begin
    state_d  = state_q;
    chirps_d = chirps_q;
    cnt_d    = cnt_q;
    flash_d  = flash_q;
    lamp_d   = 1'b0;
`ifdef ANNUNCIATOR_SIREN_TIMEOUT_EN
    snd_d    = snd_q;
`endif
    if (state_q == StHoldoff) begin
      if (arm_fall) begin
        state_d  = StChirpOn;
        chirps_d = 2'd2;
        cnt_d    = '0;
      end else if (!bus.siren_req) begin
        state_d = StIdle;
      end
    end else if (arm_fall) begin
      state_d  = StChirpOn;
      chirps_d = 2'd2;
      cnt_d    = '0;
    end else if (bus.siren_req && bus.system_arm) begin
      if (state_q != StSound) begin
        state_d = StSound;
        flash_d = '0;
        lamp_d  = 1'b1;
`ifdef ANNUNCIATOR_SIREN_TIMEOUT_EN
        snd_d   = '0;
`endif
      end else begin
        if (flash_q == CW'(FLASH_HALF - 1)) begin
          flash_d = '0;
          lamp_d  = ~lamp_q;
        end else begin
          flash_d = flash_q + 1'b1;
          lamp_d  = lamp_q;
        end
`ifdef ANNUNCIATOR_SIREN_TIMEOUT_EN
        if (snd_q == CW'(SIREN_MAX - 1)) begin
          state_d = StHoldoff;
        end else begin
          snd_d = snd_q + 1'b1;
        end
`endif
      end
    end else if (arm_rise) begin
      state_d  = StChirpOn;
      chirps_d = 2'd1;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        StChirpOn: begin
          if (cnt_q == CW'(CHIRP_LEN - 1)) begin
            cnt_d    = '0;
            chirps_d = chirps_q - 2'd1;
            state_d  = (chirps_q == 2'd1) ? StIdle : StChirpOff;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StChirpOff: begin
          if (cnt_q == CW'(CHIRP_GAP - 1)) begin
            cnt_d   = '0;
            state_d = StChirpOn;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StSound: state_d = StIdle;
        default: ;
      endcase
    end

    horn_d = (state_d == StChirpOn) || (state_d == StSound);
    if (state_d != StSound) begin
      lamp_d = (state_d == StChirpOn);
    end
  end

  assign tone_run   = (state_d == StSound);
  assign tone_start = (state_d == StSound) && (state_q != StSound);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      chirps_q  <= 2'd0;
      cnt_q     <= '0;
      flash_q   <= '0;
      arm_q     <= 1'b0;
      edge_ok_q <= 1'b0;
      horn_q    <= 1'b0;
      lamp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      chirps_q  <= chirps_d;
      cnt_q     <= cnt_d;
      flash_q   <= flash_d;
      arm_q     <= bus.system_arm;
      edge_ok_q <= 1'b1;
      horn_q    <= horn_d;
      lamp_q    <= lamp_d;
    end
  end

`ifdef ANNUNCIATOR_SIREN_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      snd_q       <= snd_d;
      timed_out_q <= (state_d == StHoldoff);
    end
  end

  assign bus.timed_out = timed_out_q;
`else
  assign bus.timed_out = 1'b0;
`endif

  annunciator_tone_gen #(
    .HI_HALF    (HI_HALF),
    .LO_HALF    (LO_HALF),
    .WARBLE_LEN (WARBLE_LEN),
    .CW         (CW)
  ) u_tone_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (tone_run),
    .start (tone_start),
    .spk   (spk)
  );

  assign bus.spk  = spk;
  assign bus.horn = horn_q;
  assign bus.lamp = lamp_q;

endmodule
